// File: rtl/decimacao_ctrl.sv
// Frame decimation controller: reads the top-left pixel of every FACTOR x FACTOR
// block from a source frame buffer and writes it in raster order to a destination buffer.
module decimacao_ctrl #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int FACTOR = 4,
    parameter int DATA_W = 8,
    localparam int OUT_W  = SRC_W / FACTOR,
    localparam int OUT_H  = SRC_H / FACTOR,
    localparam int N_OUT  = OUT_W * OUT_H,
    localparam int SRC_AW = $clog2(SRC_W * SRC_H),
    localparam int DST_AW = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [SRC_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [DST_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [SRC_AW-1:0] ROW_STEP = SRC_AW'(FACTOR * SRC_W);
    localparam logic [SRC_AW-1:0] COL_STEP = SRC_AW'(FACTOR);
    localparam logic [DST_AW-1:0] OX_LAST  = DST_AW'(OUT_W - 1);
    localparam logic [DST_AW-1:0] OY_LAST  = DST_AW'(OUT_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state;
    logic [DST_AW-1:0] ox;
    logic [DST_AW-1:0] oy;
    logic [DST_AW-1:0] idx;
    logic [SRC_AW-1:0] row_acc;
    logic [SRC_AW-1:0] col_acc;
    logic              last;
    logic              adv;
    logic              clr;

    assign last    = (ox == OX_LAST) && (oy == OY_LAST);
    assign adv     = (state == RUN) && !abort && !last;
    assign clr     = (state == RUN) && (abort || last);
    assign rd_addr = row_acc + col_acc;
    assign wr_data = rd_data;

    // Position of the read currently on the bus; zero whenever no frame is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox      <= '0;
            oy      <= '0;
            idx     <= '0;
            row_acc <= '0;
            col_acc <= '0;
        end else if (clr) begin
            ox      <= '0;
            oy      <= '0;
            idx     <= '0;
            row_acc <= '0;
            col_acc <= '0;
        end else if (adv) begin
            idx <= idx + DST_AW'(1);
            if (ox == OX_LAST) begin
                ox      <= '0;
                oy      <= oy + DST_AW'(1);
                col_acc <= '0;
                row_acc <= row_acc + ROW_STEP;
            end else begin
                ox      <= ox + DST_AW'(1);
                col_acc <= col_acc + COL_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        rd_en   <= 1'b0;
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                        if (last) begin
                            state <= FLUSH;
                            rd_en <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // The final write is on the bus this cycle regardless of abort.
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    busy    <= 1'b0;
                    done    <= !abort;
                    state   <= abort ? IDLE : DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
